// File: rtl/sa_req_gen.sv
// -----------------------------------------------------------------------------
// sa_req_gen -- registered switch-allocation request generator.
//
// Sits between the VC allocator and the switch allocator. For every input
// port a small FSM picks one eligible input VC round-robin, raises a held
// one-hot output-port request, and pulses a dequeue to that VC once the
// switch allocator grants the request.
//
// An input VC is eligible when it holds a VC grant (lowest set bit of its
// grant row names the output VC), has a buffered flit, and that output VC
// has at least one downstream credit.
//
// Optional feature (compile-time macro SA_REQ_TIMEOUT_EN):
//   defined   -> a request held TIMEOUT cycles without a grant is withdrawn
//                and the round-robin pointer moves past the stalled VC.
//   undefined -> requests are held until granted or invalidated.
//
// Ports:
//   clk               clock
//   reset_n           asynchronous active-low reset
//   vc_grants         [in VC][out VC] VC-allocation result
//   vc_flit_valid     per input VC: buffer non-empty
//   out_credit_avail  per output VC: downstream credit available
//   sa_grant          [in port][out port] switch-allocation result
//   port_req          [in port] one-hot (or zero) output-port request
//   req_vc            [in port] local VC index behind port_req
//   vc_dequeue        per input VC: one-cycle pulse, flit was switched
// -----------------------------------------------------------------------------
module sa_req_gen #(
    parameter int NUM_PORTS = 5,
    parameter int NUM_VC    = 2,
    parameter int TIMEOUT   = 16,
    localparam int VC_W     = $clog2(NUM_VC),
    localparam int NUM_IVC  = NUM_PORTS * NUM_VC
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_IVC-1:0][NUM_IVC-1:0]   vc_grants,
    input  logic [NUM_IVC-1:0]                vc_flit_valid,
    input  logic [NUM_IVC-1:0]                out_credit_avail,
    input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] sa_grant,
    output logic [NUM_PORTS-1:0][NUM_PORTS-1:0] port_req,
    output logic [NUM_PORTS-1:0][VC_W-1:0]    req_vc,
    output logic [NUM_IVC-1:0]                vc_dequeue
);

    localparam int OVC_W = (NUM_IVC > 1) ? $clog2(NUM_IVC) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Parameter sanity: fewer than two VCs or a timeout below two cycles
    // leaves the round-robin / hold counter meaningless.
    if (NUM_VC < 2 || TIMEOUT < 2) begin : g_param_check
        $error("sa_req_gen: NUM_VC and TIMEOUT must both be >= 2");
    end

    // Lowest set bit of a grant row; rows with several bits use the lowest.
    function automatic logic [OVC_W-1:0] lowest_set(input logic [NUM_IVC-1:0] row);
        logic [OVC_W-1:0] idx;
        idx = '0;
        for (int k = NUM_IVC - 1; k >= 0; k--) begin
            if (row[k]) begin
                idx = OVC_W'(k);
            end
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Per input VC: target output VC and eligibility
    // ------------------------------------------------------------------
    logic [OVC_W-1:0]   tgt_ovc [NUM_IVC];
    logic [NUM_IVC-1:0] has_grant;
    logic [NUM_IVC-1:0] elig;

    for (genvar gi = 0; gi < NUM_IVC; gi++) begin : g_vc
        assign tgt_ovc[gi]   = lowest_set(vc_grants[gi]);
        assign has_grant[gi] = |vc_grants[gi];
        assign elig[gi]      = vc_flit_valid[gi] & has_grant[gi]
                               & out_credit_avail[tgt_ovc[gi]];
    end

    // ------------------------------------------------------------------
    // Per input port: round-robin pick + IDLE/REQ FSM
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        state_t               state_reg;
        logic [VC_W-1:0]      rr_ptr_reg;
        logic [VC_W-1:0]      req_vc_reg;
        logic [OVC_W-1:0]     tgt_ovc_reg;   // target latched at issue
        logic [NUM_PORTS-1:0] port_req_reg;
        logic [NUM_VC-1:0]    deq_reg;

        logic                 found;
        logic [VC_W-1:0]      pick_vc;
        logic [OVC_W-1:0]     pick_ovc;
        logic [NUM_PORTS-1:0] pick_onehot;
        logic                 held_ok;
        logic                 granted;
        logic [VC_W-1:0]      next_ptr;
        logic [NUM_VC-1:0]    deq_onehot;

`ifdef SA_REQ_TIMEOUT_EN
        localparam int CNT_W = $clog2(TIMEOUT);
        logic [CNT_W-1:0]     cnt_reg;
`endif

        // First eligible local VC starting at the pointer, with wrap.
        always_comb begin
            found       = 1'b0;
            pick_vc     = '0;
            for (int off = 0; off < NUM_VC; off++) begin
                int idx;
                idx = (int'(rr_ptr_reg) + off) % NUM_VC;
                if (!found && elig[gi*NUM_VC + idx]) begin
                    found   = 1'b1;
                    pick_vc = VC_W'(idx);
                end
            end
            pick_ovc    = tgt_ovc[gi*NUM_VC + int'(pick_vc)];
            pick_onehot = '0;
            pick_onehot[int'(pick_ovc) / NUM_VC] = 1'b1;
        end

        // Validity of the held request uses the latched target output VC;
        // a rewritten (but non-empty) grant row does not retarget it.
        always_comb begin
            held_ok    = vc_flit_valid[gi*NUM_VC + int'(req_vc_reg)]
                         & has_grant[gi*NUM_VC + int'(req_vc_reg)]
                         & out_credit_avail[tgt_ovc_reg];
            granted    = |(sa_grant[gi] & port_req_reg);
            next_ptr   = (int'(req_vc_reg) == NUM_VC - 1) ? '0 : req_vc_reg + VC_W'(1);
            deq_onehot = '0;
            deq_onehot[req_vc_reg] = 1'b1;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_reg    <= IDLE;
                rr_ptr_reg   <= '0;
                req_vc_reg   <= '0;
                tgt_ovc_reg  <= '0;
                port_req_reg <= '0;
                deq_reg      <= '0;
`ifdef SA_REQ_TIMEOUT_EN
                cnt_reg      <= '0;
`endif
            end else begin
                deq_reg <= '0;
                case (state_reg)
                    IDLE: begin
                        if (found) begin
                            port_req_reg <= pick_onehot;
                            req_vc_reg   <= pick_vc;
                            tgt_ovc_reg  <= pick_ovc;
                            state_reg    <= REQ;
`ifdef SA_REQ_TIMEOUT_EN
                            cnt_reg      <= '0;
`endif
                        end
                    end
                    REQ: begin
                        // Grant has priority over any withdrawal reason.
                        if (granted) begin
                            deq_reg      <= deq_onehot;
                            port_req_reg <= '0;
                            rr_ptr_reg   <= next_ptr;
                            state_reg    <= IDLE;
                        end else if (!held_ok) begin
                            port_req_reg <= '0;
                            state_reg    <= IDLE;
                        end
`ifdef SA_REQ_TIMEOUT_EN
                        else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                            // Stalled too long: give the other VCs a turn.
                            port_req_reg <= '0;
                            rr_ptr_reg   <= next_ptr;
                            state_reg    <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_W'(1);
                        end
`endif
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end

        assign port_req[gi]                     = port_req_reg;
        assign req_vc[gi]                       = req_vc_reg;
        assign vc_dequeue[gi*NUM_VC +: NUM_VC]  = deq_reg;
    end

endmodule

// File: tb/tb_sa_req_gen.sv
// -----------------------------------------------------------------------------
// Testbench for sa_req_gen (NUM_PORTS=5, NUM_VC=2, TIMEOUT=4).
// Stimulus pushes the expected output events (request issue / request drop,
// with dequeue bits and cycle number) into a queue; a monitor running on the
// falling edge detects every port_req change or dequeue pulse and compares it
// against the head of the queue.
// -----------------------------------------------------------------------------
module tb_sa_req_gen;

    localparam int NP  = 5;
    localparam int NVC = 2;
    localparam int NV  = NP * NVC;
    localparam int VW  = 1;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NV-1:0][NV-1:0] vc_grants;
    logic [NV-1:0]         vc_flit_valid;
    logic [NV-1:0]         out_credit_avail;
    logic [NP-1:0][NP-1:0] sa_grant;
    logic [NP-1:0][NP-1:0] port_req;
    logic [NP-1:0][VW-1:0] req_vc;
    logic [NV-1:0]         vc_dequeue;

    always #5 clk = ~clk;

    sa_req_gen #(
        .NUM_PORTS (NP),
        .NUM_VC    (NVC),
        .TIMEOUT   (4)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .vc_grants        (vc_grants),
        .vc_flit_valid    (vc_flit_valid),
        .out_credit_avail (out_credit_avail),
        .sa_grant         (sa_grant),
        .port_req         (port_req),
        .req_vc           (req_vc),
        .vc_dequeue       (vc_dequeue)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            port;
        logic [NP-1:0] req;
        int            vc;
        logic [NVC-1:0] deq;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    logic [NP-1:0] prev_req [NP] = '{default: '0};

    task automatic expect_ev(input int c, input int p, input logic [NP-1:0] r,
                             input int v, input logic [NVC-1:0] d);
        ev_t e;
        e.cyc = c; e.port = p; e.req = r; e.vc = v; e.deq = d;
        exp_q.push_back(e);
    endtask

    // Monitor: any change of a port's request, or any dequeue pulse, is an event.
    always @(negedge clk) begin
        ev_t e;
        for (int i = 0; i < NP; i++) begin
            logic [NVC-1:0] d;
            d = vc_dequeue[i*NVC +: NVC];
            if (port_req[i] !== prev_req[i] || d != '0) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event: got cyc=%0d port=%0d req=%b vc=%0d deq=%b, required no event",
                             cyc, i, port_req[i], req_vc[i], d);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.port != i || e.req !== port_req[i] ||
                        (e.req != '0 && e.vc != int'(req_vc[i])) || e.deq !== d) begin
                        bad++;
                        $display("FAIL event: got cyc=%0d port=%0d req=%b vc=%0d deq=%b, required cyc=%0d port=%0d req=%b vc=%0d deq=%b",
                                 cyc, i, port_req[i], req_vc[i], d, e.cyc, e.port, e.req, e.vc, e.deq);
                    end else begin
                        $display("ok   cyc=%0d port=%0d req=%b vc=%0d deq=%b",
                                 cyc, i, port_req[i], req_vc[i], d);
                    end
                end
            end
            prev_req[i] = port_req[i];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end else begin
            $display("ok   %s = %0h", nm, got);
        end
    endtask

    // Issue expected at t+1, grant output port j after 'hold' cycles of
    // request, drop + dequeue expected the cycle after the grant.
    // Returns at the cycle the drop is visible (port back in IDLE).
    task automatic grant_round(input int p, input logic [NP-1:0] r, input int v,
                               input int j, input int hold);
        int t;
        logic [NVC-1:0] dm;
        t  = cyc;
        dm = '0;
        dm[v] = 1'b1;
        expect_ev(t + 1, p, r, v, '0);
        repeat (1 + hold) step();
        sa_grant[p][j] = 1'b1;
        expect_ev(t + 2 + hold, p, '0, v, dm);
        step();
        sa_grant[p][j] = 1'b0;
    endtask

    initial begin
        int t;
        reset_n          = 1'b0;
        vc_grants        = '0;
        vc_flit_valid    = '0;
        out_credit_avail = '0;
        sa_grant         = '0;
        repeat (2) step();
        check("reset_port_req",   32'(port_req),   32'd0);
        check("reset_req_vc",     32'(req_vc),     32'd0);
        check("reset_vc_dequeue", 32'(vc_dequeue), 32'd0);
        reset_n = 1'b1;
        step();

        // Grant path: VC0 -> out VC6 (port 3), granted two cycles after issue.
        vc_grants[0]        = 10'b0001000000;
        vc_flit_valid[0]    = 1'b1;
        out_credit_avail[6] = 1'b1;
        grant_round(0, 5'b01000, 0, 3, 2);
        vc_flit_valid[0]    = 1'b0;
        step();

        // Round-robin: VC1 -> out VC2 (port 1) added; pointer now 1.
        vc_grants[1]        = 10'b0000000100;
        out_credit_avail[2] = 1'b1;
        vc_flit_valid[0]    = 1'b1;
        vc_flit_valid[1]    = 1'b1;
        grant_round(0, 5'b00010, 1, 1, 1);
        grant_round(0, 5'b01000, 0, 3, 1);
        grant_round(0, 5'b00010, 1, 1, 1);
        vc_flit_valid       = '0;
        step();

        // Withdrawal by credit drop; pointer (0) must not move.
        t = cyc;
        vc_flit_valid[0] = 1'b1;
        vc_flit_valid[1] = 1'b1;
        expect_ev(t + 1, 0, 5'b01000, 0, '0);
        step(); step();
        out_credit_avail[6] = 1'b0;
        expect_ev(t + 3, 0, 5'b00000, 0, '0);
        step();
        out_credit_avail[6] = 1'b1;
        expect_ev(t + 4, 0, 5'b01000, 0, '0);
        step(); step();
        // Non-matching grant bits (wrong port / idle port): no effect.
        sa_grant[0][1] = 1'b1;
        sa_grant[1][3] = 1'b1;
        step();
        sa_grant[0][1] = 1'b0;
        sa_grant[1][3] = 1'b0;
        // Credit drop and matching grant together: grant wins.
        out_credit_avail[6] = 1'b0;
        sa_grant[0][3]      = 1'b1;
        expect_ev(t + 7, 0, 5'b00000, 0, 2'b01);
        step();
        sa_grant[0][3]      = 1'b0;
        out_credit_avail[6] = 1'b1;
        vc_flit_valid       = '0;
        step();

        // Port 2: multi-bit row uses lowest bit (out VC3, port 1); all-zero
        // row on VC5 is ineligible; a rewritten row during REQ is ignored.
        t = cyc;
        vc_grants[4]        = 10'b1000001000;
        out_credit_avail[3] = 1'b1;
        vc_flit_valid[4]    = 1'b1;
        vc_flit_valid[5]    = 1'b1;
        expect_ev(t + 1, 2, 5'b00010, 0, '0);
        step();
        vc_grants[4] = 10'b0010000000;
        step();
        sa_grant[2][1] = 1'b1;
        expect_ev(t + 3, 2, 5'b00000, 0, 2'b01);
        step();
        sa_grant[2][1] = 1'b0;
        vc_flit_valid  = '0;
        vc_grants[4]   = '0;
        step();

        // Reset mid-REQ: request dropped immediately, no dequeue. Pointer is 1.
        t = cyc;
        vc_flit_valid[1] = 1'b1;
        expect_ev(t + 1, 0, 5'b00010, 1, '0);
        step(); step();
        expect_ev(t + 2, 0, 5'b00000, 0, '0);
        reset_n = 1'b0;
        #1;
        check("midreset_port_req",   32'(port_req),   32'd0);
        check("midreset_vc_dequeue", 32'(vc_dequeue), 32'd0);
        check("midreset_req_vc",     32'(req_vc),     32'd0);
        vc_flit_valid = '0;
        step(); step();
        reset_n = 1'b1;
        step();

        // Hold ungranted. Pointer is 0 after reset.
        t = cyc;
        vc_flit_valid[0] = 1'b1;
        vc_flit_valid[1] = 1'b1;
`ifdef SA_REQ_TIMEOUT_EN
        expect_ev(t + 1, 0, 5'b01000, 0, '0);
        expect_ev(t + 5, 0, 5'b00000, 0, '0);
        repeat (5) step();
        grant_round(0, 5'b00010, 1, 1, 1);
`else
        grant_round(0, 5'b01000, 0, 3, 6);
`endif
        vc_flit_valid = '0;
        repeat (4) step();

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
